adder_share_arbiter: RTL
========================

Name: adder_share_arbiter

Overview:
Shares one registered adder datapath (same shape as clocked_adder: A/B in, registered sum of WIDTH+1 bits out) among NUM_REQ requesters. The arbiter grants requesters round-robin and drives the winner's operands into the adder. It waits out the adder latency, then returns the sum tagged with a one-hot requester ID. It sits between the operand producers and the shared adder instance, and serialises adder use so that each power-estimation run has a known toggle sequence.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 4, operand width; sum is WIDTH+1
ADD_LAT, 1, adder latency: clock edges from operands applied to sum valid (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  NUM_REQ  per-requester operation request
req_a  input  NUM_REQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  packed operand B, same packing as req_a
req_ready  output  NUM_REQ  one-hot accept; a transfer occurs on the edge where req_valid[i] & req_ready[i]
add_a  output  WIDTH  registered operand A to the shared adder
add_b  output  WIDTH  registered operand B to the shared adder
add_sum  input  WIDTH+1  sum from the shared adder
resp_valid  output  NUM_REQ  one-hot, one-cycle pulse identifying the owner of resp_sum
resp_sum  output  WIDTH+1  captured sum, held until the next response
busy  output  1  high while an operation is in flight

Behaviour:
- Reset (async assert, sync-released): state=IDLE, req_ready=0, add_a=0, add_b=0, resp_valid=0, resp_sum=0, busy=0, rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, WAIT, CAPTURE.
- IDLE:
  - Winner g = first i with req_valid[i], searching from rr_ptr+1 upward and wrapping modulo NUM_REQ.
  - req_ready[g] is asserted combinationally; req_ready is 0 in all other states.
  - On the accepting edge: add_a<=A[g], add_b<=B[g], rr_ptr<=g, cnt<=ADD_LAT, state->WAIT.
  - If no req_valid is asserted: stay in IDLE; add_a/add_b hold their values (no spurious toggles).
- WAIT: cnt decrements each edge. When cnt==1 on an edge, state->CAPTURE. WAIT lasts exactly ADD_LAT cycles.
- CAPTURE:
  - On the next edge: resp_sum<=add_sum, resp_valid<=onehot(rr_ptr), state->IDLE.
  - resp_valid is high for exactly one cycle.
- Latency: accepting edge to resp_valid high = ADD_LAT+1 edges.
- Back-to-back: a new request can be accepted in the same cycle resp_valid is high. Peak throughput is one operation per ADD_LAT+2 cycles.
- busy = (state != IDLE).
- Arithmetic: no truncation. resp_sum carries the full WIDTH+1 bits (15+15=30 with WIDTH=4).
- req_valid deasserting before it is granted is legal; that requester is simply not served. Operands are sampled only on the accepting edge; later changes are ignored.
- Simultaneous requests: strict round-robin. A continuously requesting requester waits at most NUM_REQ-1 other grants.
- Reset mid-operation: the in-flight operation is discarded and no resp_valid pulse is issued. All state returns to reset values.
- Unused NUM_REQ slices contribute nothing. rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
Macro ADDER_ARB_STATS_EN.
- Defined:
  - Adds output ops_count[15:0] and output conflict_count[15:0].
  - ops_count increments on each resp_valid pulse.
  - conflict_count increments on each accepting edge where more than one req_valid bit was high.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter exists, and the core behaviour is unchanged.

Test Plan:
All scenarios use NUM_REQ=4, WIDTH=4, ADD_LAT=1, with a registered-adder model on add_sum.
1. Hold rst_n=0 -> req_ready=0000, resp_valid=0000, resp_sum=0, add_a=add_b=0, busy=0; after release, idle inputs -> add_a/add_b never toggle.
2. req_valid=0001, A0=2, B0=3 -> req_ready=0001 in the same cycle; 2 edges after accept: resp_valid=0001, resp_sum=5; busy high for 2 cycles.
3. All four valid at once: (2,3), (15,15), (8,6), (4,5) -> grants in order 0,1,2,3; resp_sum=5,30,14,9 with resp_valid=0001,0010,0100,1000; one response every 3 cycles.
4. req_valid=0101 held continuously -> grants alternate 0,2,0,2 over 6 operations; no starvation.
5. Assert rst_n=0 during WAIT of an operation for requester 1 -> no resp_valid pulse; after release, a request from requester 1 alone is granted first and completes correctly.
6. With ADDER_ARB_STATS_EN defined, run scenario 3 then one single request -> ops_count=5, conflict_count=3.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one registered adder among NUM_REQ requesters.
// Optional statistics counters are enabled with `define ADDER_ARB_STATS_EN.
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH:0]           add_sum,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH:0]           resp_sum,
  output logic                     busy
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [15:0]              ops_count,
  output logic [15:0]              conflict_count
`endif
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [CW-1:0] cnt;
  logic [PW-1:0] grant_idx;
  logic          grant_found;
  logic          accept;

  // Index base+off reduced modulo NUM_REQ (off never exceeds NUM_REQ).
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(NUM_REQ)) s = s - 32'(NUM_REQ);
    return PW'(s);
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= 32'(NUM_REQ); k++) begin
      if (!grant_found && req_valid[wrap_add(rr_ptr, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(rr_ptr, k);
      end
    end
  end

  assign accept = (state == IDLE) && grant_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= PW'(NUM_REQ - 1);
      cnt        <= '0;
      add_a      <= '0;
      add_b      <= '0;
      resp_valid <= '0;
      resp_sum   <= '0;
    end else begin
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            add_a  <= req_a[grant_idx*WIDTH +: WIDTH];
            add_b  <= req_b[grant_idx*WIDTH +: WIDTH];
            rr_ptr <= grant_idx;
            cnt    <= CW'(ADD_LAT);
            state  <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= CAPTURE;
        end
        CAPTURE: begin
          resp_sum           <= add_sum;
          resp_valid[rr_ptr] <= 1'b1;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDER_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_count      <= '0;
      conflict_count <= '0;
    end else begin
      if (state == CAPTURE && ops_count != '1) ops_count <= ops_count + 1'b1;
      if (accept && ($countones(req_valid) > 1) && conflict_count != '1)
        conflict_count <= conflict_count + 1'b1;
    end
  end
`endif

endmodule
